// File: rtl/bpred_pkg.sv
// Shared constants and helpers for the perceptron branch predictor.
package bpred_pkg;

    localparam int HIST_LEN_DEFAULT    = 12;
    localparam int TABLE_DEPTH_DEFAULT = 64;
    localparam int WEIGHT_W_DEFAULT    = 8;

    // Training threshold floor(1.93*h + 14), kept in integer arithmetic.
    function automatic int thetaFor(input int histLen);
        return (193 * histLen + 1400) / 100;
    endfunction

    localparam int THETA_DEFAULT = thetaFor(HIST_LEN_DEFAULT);

    // Symmetric saturation limits so that negating a weight never overflows.
    function automatic int weightMax(input int weightW);
        return (1 << (weightW - 1)) - 1;
    endfunction

    function automatic int weightMin(input int weightW);
        return -weightMax(weightW);
    endfunction

    localparam logic [1:0] DBG_LOOKUP_COUNT     = 2'b00;
    localparam logic [1:0] DBG_UPDATE_COUNT     = 2'b01;
    localparam logic [1:0] DBG_MISPREDICT_COUNT = 2'b10;
    localparam logic [1:0] DBG_GHR              = 2'b11;

    typedef enum logic {
        INIT_SWEEP,
        INIT_READY
    } initState_e;

endpackage

// File: rtl/perceptron_dot.sv
// Signed dot product of one perceptron row against the global history.
module perceptron_dot
    import bpred_pkg::*;
#(
    parameter int HIST_LEN   = HIST_LEN_DEFAULT,
    parameter int WEIGHT_W   = WEIGHT_W_DEFAULT,
    localparam int SUM_W     = WEIGHT_W + $clog2(HIST_LEN + 1)
) (
    input  logic [(HIST_LEN+1)*WEIGHT_W-1:0] weights_i,
    input  logic [HIST_LEN-1:0]              ghr_i,
    output logic signed [SUM_W-1:0]          sum_o
);

    logic [HIST_LEN:0]       xVec;
    logic signed [SUM_W-1:0] terms [HIST_LEN+1];

    // Bias input is always +1, history bits map 1 -> +1 and 0 -> -1.
    assign xVec = {ghr_i, 1'b1};

    for (genvar i = 0; i <= HIST_LEN; i++) begin : g_term
        logic [WEIGHT_W-1:0]     w;
        logic signed [SUM_W-1:0] wExt;
        assign w       = weights_i[i*WEIGHT_W +: WEIGHT_W];
        assign wExt    = {{(SUM_W-WEIGHT_W){w[WEIGHT_W-1]}}, w};
        assign terms[i] = xVec[i] ? wExt : -wExt;
    end

    // Accumulate all signed terms at full sum width; the width is sized so this cannot overflow.
    always_comb begin
        sum_o = '0;
        for (int i = 0; i <= HIST_LEN; i++) begin
            sum_o = sum_o + terms[i];
        end
    end

endmodule

// File: rtl/perceptron_bpred.sv
// Perceptron branch predictor: weight table, training, global history, init sweep and counters.
module perceptron_bpred
    import bpred_pkg::*;
#(
    parameter int HIST_LEN    = HIST_LEN_DEFAULT,
    parameter int TABLE_DEPTH = TABLE_DEPTH_DEFAULT,
    parameter int WEIGHT_W    = WEIGHT_W_DEFAULT,
    parameter int THETA       = thetaFor(HIST_LEN),
    localparam int IDX_W      = $clog2(TABLE_DEPTH),
    localparam int SUM_W      = WEIGHT_W + $clog2(HIST_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    lu_valid,
    input  logic [31:0]             lu_pc,
    output logic                    ready,
    output logic                    pred_valid,
    output logic                    pred_taken,
    output logic signed [SUM_W-1:0] pred_sum,
    output logic [HIST_LEN-1:0]     pred_ghr,
    input  logic                    up_valid,
    input  logic [31:0]             up_pc,
    input  logic                    up_taken,
    input  logic                    up_mispredict,
    input  logic signed [SUM_W-1:0] up_sum,
    input  logic [HIST_LEN-1:0]     up_ghr,
    input  logic [1:0]              debug_sel,
    output logic [31:0]             debug_out
);

    localparam int ROW_W = (HIST_LEN + 1) * WEIGHT_W;
    localparam logic signed [WEIGHT_W-1:0] W_MAX = WEIGHT_W'(weightMax(WEIGHT_W));
    localparam logic signed [WEIGHT_W-1:0] W_MIN = WEIGHT_W'(weightMin(WEIGHT_W));

    initState_e              state_q, state_d;
    logic [IDX_W-1:0]        sweepIdx_q, sweepIdx_d;
    logic                    sweepWe;
    logic [ROW_W-1:0]        table_q [TABLE_DEPTH];
    logic [HIST_LEN-1:0]     ghr_q, ghr_d;
    logic [31:0]             lookupCount_q, updateCount_q, mispredictCount_q;
    logic                    predValid_q, predTaken_q;
    logic signed [SUM_W-1:0] predSum_q;
    logic [HIST_LEN-1:0]     predGhr_q;

    logic [IDX_W-1:0]        luIdx, upIdx;
    logic signed [SUM_W-1:0] luSum;
    logic                    luTaken, luAccept, upAccept, upRecover, train;
    logic [SUM_W:0]          upSumExt, upMag;
    logic [ROW_W-1:0]        upRow, trainedRow;
    logic [HIST_LEN:0]       upXVec;
    logic signed [WEIGHT_W-1:0] curWeight;
    logic                    unusedPcBits;

    assign luIdx        = lu_pc[IDX_W+1:2];
    assign upIdx        = up_pc[IDX_W+1:2];
    assign unusedPcBits = ^{lu_pc[31:IDX_W+2], lu_pc[1:0], up_pc[31:IDX_W+2], up_pc[1:0]};

    assign ready     = (state_q == INIT_READY);
    assign upAccept  = up_valid & ready;
    assign upRecover = upAccept & up_mispredict;
    assign luAccept  = lu_valid & ready & ~(up_valid & up_mispredict);
    assign luTaken   = ~luSum[SUM_W-1];

    assign upSumExt = {up_sum[SUM_W-1], up_sum};
    assign upMag    = up_sum[SUM_W-1] ? (~upSumExt + (SUM_W+1)'(1)) : upSumExt;
    assign train    = upAccept & (up_mispredict | (upMag <= (SUM_W+1)'(THETA)));

    perceptron_dot #(
        .HIST_LEN (HIST_LEN),
        .WEIGHT_W (WEIGHT_W)
    ) u_dot (
        .weights_i (table_q[luIdx]),
        .ghr_i     (ghr_q),
        .sum_o     (luSum)
    );

    // Init sweep: zero one row per cycle from row 0, then open the block for requests.
    always_comb begin
        state_d    = state_q;
        sweepIdx_d = sweepIdx_q;
        sweepWe    = 1'b0;
        case (state_q)
            INIT_SWEEP: begin
                sweepWe    = 1'b1;
                sweepIdx_d = sweepIdx_q + IDX_W'(1);
                if (sweepIdx_q == IDX_W'(TABLE_DEPTH - 1)) begin
                    state_d = INIT_READY;
                end
            end
            INIT_READY: begin
                state_d = INIT_READY;
            end
            default: begin
                state_d = INIT_SWEEP;
            end
        endcase
    end

    // History update: a mispredict recovery wins over the speculative shift of a lookup.
    always_comb begin
        ghr_d = ghr_q;
        if (upRecover) begin
            ghr_d = {up_ghr[HIST_LEN-2:0], up_taken};
        end else if (luAccept) begin
            ghr_d = {ghr_q[HIST_LEN-2:0], luTaken};
        end
    end

    // Training: move every weight one step toward agreement with the outcome, saturating symmetrically.
    always_comb begin
        upRow      = table_q[upIdx];
        trainedRow = upRow;
        upXVec     = {up_ghr, 1'b1};
        curWeight  = '0;
        for (int i = 0; i <= HIST_LEN; i++) begin
            curWeight = upRow[i*WEIGHT_W +: WEIGHT_W];
            if (up_taken == upXVec[i]) begin
                if (curWeight < W_MAX) curWeight = curWeight + WEIGHT_W'(1);
            end else begin
                if (curWeight > W_MIN) curWeight = curWeight - WEIGHT_W'(1);
            end
            trainedRow[i*WEIGHT_W +: WEIGHT_W] = curWeight;
        end
    end

    // Weight table: sweep writes take priority; training only happens once the sweep is done.
    always_ff @(posedge clk) begin
        if (sweepWe) begin
            table_q[sweepIdx_q] <= '0;
        end else if (train) begin
            table_q[upIdx] <= trainedRow;
        end
    end

    // Control state, history, prediction outputs and event counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= INIT_SWEEP;
            sweepIdx_q        <= '0;
            ghr_q             <= '0;
            lookupCount_q     <= '0;
            updateCount_q     <= '0;
            mispredictCount_q <= '0;
            predValid_q       <= 1'b0;
            predTaken_q       <= 1'b0;
            predSum_q         <= '0;
            predGhr_q         <= '0;
        end else begin
            state_q     <= state_d;
            sweepIdx_q  <= sweepIdx_d;
            ghr_q       <= ghr_d;
            predValid_q <= luAccept;
            if (luAccept) begin
                predTaken_q   <= luTaken;
                predSum_q     <= luSum;
                predGhr_q     <= ghr_q;
                lookupCount_q <= lookupCount_q + 32'd1;
            end
            if (upAccept) begin
                updateCount_q <= updateCount_q + 32'd1;
            end
            if (upRecover) begin
                mispredictCount_q <= mispredictCount_q + 32'd1;
            end
        end
    end

    assign pred_valid = predValid_q;
    assign pred_taken = predTaken_q;
    assign pred_sum   = predSum_q;
    assign pred_ghr   = predGhr_q;

    // Debug readback of counters and the current history.
    always_comb begin
        debug_out = '0;
        case (debug_sel)
            DBG_LOOKUP_COUNT:     debug_out = lookupCount_q;
            DBG_UPDATE_COUNT:     debug_out = updateCount_q;
            DBG_MISPREDICT_COUNT: debug_out = mispredictCount_q;
            DBG_GHR:              debug_out = 32'(ghr_q);
            default:              debug_out = '0;
        endcase
    end

endmodule

// File: tb/tb_perceptron_bpred.sv
// Directed bench for perceptron_bpred with hand-computed expected values.
module tb_perceptron_bpred;

    localparam int HIST_LEN = 12;
    localparam int SUM_W    = 12;

    logic                    clk;
    logic                    reset_n;
    logic                    lu_valid;
    logic [31:0]             lu_pc;
    logic                    ready;
    logic                    pred_valid;
    logic                    pred_taken;
    logic signed [SUM_W-1:0] pred_sum;
    logic [HIST_LEN-1:0]     pred_ghr;
    logic                    up_valid;
    logic [31:0]             up_pc;
    logic                    up_taken;
    logic                    up_mispredict;
    logic signed [SUM_W-1:0] up_sum;
    logic [HIST_LEN-1:0]     up_ghr;
    logic [1:0]              debug_sel;
    logic [31:0]             debug_out;

    int checks = 0;
    int errors = 0;
    int lowCycles;

    perceptron_bpred dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .lu_valid      (lu_valid),
        .lu_pc         (lu_pc),
        .ready         (ready),
        .pred_valid    (pred_valid),
        .pred_taken    (pred_taken),
        .pred_sum      (pred_sum),
        .pred_ghr      (pred_ghr),
        .up_valid      (up_valid),
        .up_pc         (up_pc),
        .up_taken      (up_taken),
        .up_mispredict (up_mispredict),
        .up_sum        (up_sum),
        .up_ghr        (up_ghr),
        .debug_sel     (debug_sel),
        .debug_out     (debug_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkDebug(input string tag, input logic [1:0] sel, input logic [31:0] expected);
        debug_sel = sel;
        #1;
        checkOutput(tag, debug_out, expected);
    endtask

    // Drive one cycle of lookup and/or update, then deassert both valids.
    task automatic applyStimulus(input logic luValid, input logic [31:0] luPc,
                                 input logic upValid, input logic [31:0] upPc,
                                 input logic upTaken, input logic upMisp,
                                 input int upSum, input logic [HIST_LEN-1:0] upGhr);
        lu_valid      = luValid;
        lu_pc         = luPc;
        up_valid      = upValid;
        up_pc         = upPc;
        up_taken      = upTaken;
        up_mispredict = upMisp;
        up_sum        = SUM_W'(upSum);
        up_ghr        = upGhr;
        tick();
        lu_valid      = 1'b0;
        up_valid      = 1'b0;
        up_mispredict = 1'b0;
    endtask

    task automatic waitReady(input string tag);
        lowCycles = 0;
        for (int c = 0; c < 80 && !ready; c++) begin
            lowCycles++;
            tick();
        end
        checkOutput({tag, "_low_cycles"}, 32'(lowCycles), 32'd64);
        checkOutput({tag, "_ready"}, 32'(ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not end, observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n       = 1'b0;
        lu_valid      = 1'b0;
        lu_pc         = '0;
        up_valid      = 1'b0;
        up_pc         = '0;
        up_taken      = 1'b0;
        up_mispredict = 1'b0;
        up_sum        = '0;
        up_ghr        = '0;
        debug_sel     = 2'b00;
        repeat (3) tick();

        $display("[TB] reset state");
        checkOutput("rst_ready", 32'(ready), 32'd0);
        checkOutput("rst_pred_valid", 32'(pred_valid), 32'd0);
        checkOutput("rst_pred_taken", 32'(pred_taken), 32'd0);
        checkOutput("rst_pred_sum", 32'(pred_sum), 32'd0);
        checkOutput("rst_pred_ghr", 32'(pred_ghr), 32'd0);
        checkDebug("rst_lookup_count", 2'b00, 32'd0);
        checkDebug("rst_ghr", 2'b11, 32'd0);

        reset_n = 1'b1;
        waitReady("init");

        $display("[TB] first lookup on zeroed table");
        applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 0, 12'h000);
        checkOutput("lu0_valid", 32'(pred_valid), 32'd1);
        checkOutput("lu0_sum", 32'(pred_sum), 32'd0);
        checkOutput("lu0_taken", 32'(pred_taken), 32'd1);
        checkOutput("lu0_ghr", 32'(pred_ghr), 32'h000);
        tick();
        checkOutput("lu0_valid_one_cycle", 32'(pred_valid), 32'd0);
        checkDebug("lu0_ghr_shift", 2'b11, 32'h001);
        checkDebug("lu0_lookup_count", 2'b00, 32'd1);

        $display("[TB] single training step");
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b0, 0, 12'h000);
        checkDebug("tr1_update_count", 2'b01, 32'd1);
        checkDebug("tr1_ghr_kept", 2'b11, 32'h001);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'hFC, 1'b0, 1'b1, 0, 12'h000);
        checkDebug("tr1_recover_ghr", 2'b11, 32'h000);
        checkDebug("tr1_mispredict_count", 2'b10, 32'd1);
        applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 0, 12'h000);
        checkOutput("tr1_sum", 32'(pred_sum), 32'd13);
        checkOutput("tr1_taken", 32'(pred_taken), 32'd1);

        $display("[TB] saturation");
        for (int n = 0; n < 130; n++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 32'h80, 1'b1, 1'b0, 0, 12'hFFF);
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 32'hFC, 1'b0, 1'b1, 0, 12'h000);
        applyStimulus(1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0, 0, 12'h000);
        checkOutput("sat_neg_sum", 32'(pred_sum), -32'sd1397);
        checkOutput("sat_neg_taken", 32'(pred_taken), 32'd0);
        checkDebug("sat_ghr_not_taken", 2'b11, 32'h000);
        checkDebug("sat_update_count", 2'b01, 32'd133);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'hFC, 1'b1, 1'b1, 0, 12'hFFF);
        checkDebug("sat_recover_ghr", 2'b11, 32'hFFF);
        applyStimulus(1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0, 0, 12'h000);
        checkOutput("sat_pos_sum", 32'(pred_sum), 32'd1651);
        checkOutput("sat_pos_ghr", 32'(pred_ghr), 32'hFFF);

        $display("[TB] recovery with same-cycle lookup");
        applyStimulus(1'b1, 32'h40, 1'b1, 32'hFC, 1'b1, 1'b1, 0, 12'h0A5);
        checkOutput("rec_squash", 32'(pred_valid), 32'd0);
        checkDebug("rec_ghr", 2'b11, 32'h14B);
        checkDebug("rec_mispredict_count", 2'b10, 32'd4);
        checkDebug("rec_lookup_count", 2'b00, 32'd4);

        $display("[TB] threshold behaviour");
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b0, 50, 12'h000);
        checkDebug("thr_update_count", 2'b01, 32'd136);
        checkDebug("thr_mispredict_count", 2'b10, 32'd4);
        applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 0, 12'h000);
        checkOutput("thr_unchanged_sum", 32'(pred_sum), 32'd3);
        checkOutput("thr_unchanged_ghr", 32'(pred_ghr), 32'h14B);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b0, -37, 12'h000);
        applyStimulus(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 1'b0, 38, 12'h000);
        applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 0, 12'h000);
        checkOutput("thr_edge_sum", 32'(pred_sum), 32'd2);
        checkOutput("thr_edge_ghr", 32'(pred_ghr), 32'h297);

        $display("[TB] same-row lookup and update");
        applyStimulus(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 0, 12'h000);
        checkOutput("byp_pre_update_sum", 32'(pred_sum), -32'sd2);
        checkOutput("byp_taken", 32'(pred_taken), 32'd0);
        applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 0, 12'h000);
        checkOutput("byp_post_update_sum", 32'(pred_sum), -32'sd3);
        checkOutput("byp_post_ghr", 32'(pred_ghr), 32'hA5E);
        checkDebug("byp_lookup_count", 2'b00, 32'd8);
        checkDebug("byp_update_count", 2'b01, 32'd139);
        checkDebug("byp_ghr", 2'b11, 32'h4BC);

        $display("[TB] reset mid-sweep");
        reset_n = 1'b0;
        #1;
        checkDebug("rst2_lookup_count", 2'b00, 32'd0);
        checkDebug("rst2_ghr", 2'b11, 32'd0);
        tick();
        reset_n       = 1'b1;
        lu_valid      = 1'b1;
        lu_pc         = 32'h40;
        up_valid      = 1'b1;
        up_pc         = 32'h40;
        up_taken      = 1'b1;
        up_mispredict = 1'b1;
        up_ghr        = 12'hFFF;
        repeat (20) tick();
        checkOutput("sweep_ready", 32'(ready), 32'd0);
        checkOutput("sweep_pred_valid", 32'(pred_valid), 32'd0);
        checkDebug("sweep_lookup_count", 2'b00, 32'd0);
        checkDebug("sweep_update_count", 2'b01, 32'd0);
        checkDebug("sweep_ghr", 2'b11, 32'd0);
        reset_n       = 1'b0;
        lu_valid      = 1'b0;
        up_valid      = 1'b0;
        up_mispredict = 1'b0;
        tick();
        reset_n = 1'b1;
        waitReady("resweep");
        applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 0, 12'h000);
        checkOutput("resweep_row16_sum", 32'(pred_sum), 32'd0);
        applyStimulus(1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0, 0, 12'h000);
        checkOutput("resweep_row32_sum", 32'(pred_sum), 32'd0);
        applyStimulus(1'b1, 32'hFC, 1'b0, 32'h0, 1'b0, 1'b0, 0, 12'h000);
        checkOutput("resweep_row63_sum", 32'(pred_sum), 32'd0);
        checkOutput("resweep_row63_ghr", 32'(pred_ghr), 32'h003);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/perceptron_bpred.md
PERCEPTRON_BPRED -- requirements
Module: perceptron_bpred

Interface
REQ-001 SHALL have parameter HIST_LEN, default 12: global history length and number of history weights.
REQ-002 SHALL have parameter TABLE_DEPTH, default 64 (power of 2): perceptron rows; IDX_W = log2(TABLE_DEPTH).
REQ-003 SHALL have parameter WEIGHT_W, default 8: signed weight width; SUM_W = WEIGHT_W + ceil(log2(HIST_LEN+1)).
REQ-004 SHALL have parameter THETA, default 37: training threshold (floor(1.93*HIST_LEN+14)).
REQ-005 SHALL have ports: clk  in  1  sole clock; reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: lu_valid  in  1  lookup request; lu_pc  in  32  fetch PC; ready  out  1  block initialised and accepting requests.
REQ-007 SHALL have ports: pred_valid  out  1; pred_taken  out  1; pred_sum  out  SUM_W  signed dot product; pred_ghr  out  HIST_LEN  GHR used by the lookup.
REQ-008 SHALL have ports: up_valid  in  1; up_pc  in  32; up_taken  in  1  resolved direction; up_mispredict  in  1; up_sum  in  SUM_W  sum from prediction; up_ghr  in  HIST_LEN  snapshot from prediction.
REQ-009 SHALL have ports: debug_sel  in  2; debug_out  out  32  (00 lookup_count, 01 update_count, 10 mispredict_count, 11 {GHR zero-extended}).

Function
REQ-010 SHALL index rows with pc[IDX_W+1:2]; row = bias w0 plus w1..wHIST_LEN.
REQ-011 SHALL compute sum = w0 + sum(wi * xi), xi = +1 if GHR[i-1]=1 else -1, at full SUM_W precision, no overflow.
REQ-012 SHALL accept a lookup in cycle N when lu_valid & ready & ~(up_valid & up_mispredict); pred_* registered, valid in N+1 for exactly one cycle; pred_taken = (sum >= 0).
REQ-013 SHALL shift GHR at end of accepted-lookup cycle: GHR <= {GHR[HIST_LEN-2:0], predicted taken}; bit 0 newest.
REQ-014 SHALL train on update in cycle N when up_valid & ready and (up_mispredict or |up_sum| <= THETA): wi += t*xi from up_ghr, t = +1 taken / -1 not taken, x0 = +1; written at end of N.
REQ-015 SHALL saturate weights to [-(2^(WEIGHT_W-1)-1), +(2^(WEIGHT_W-1)-1)], never wrap.
REQ-016 SHALL, on up_valid & up_mispredict, set GHR <= {up_ghr[HIST_LEN-2:0], up_taken}; recovery overrides lookup shift; same-cycle lookup squashed (pred_valid=0 at N+1).
REQ-017 SHALL give a same-cycle lookup and update to the same row the pre-update weights (no bypass).
REQ-018 SHALL count: lookup_count per accepted lookup, update_count per accepted update, mispredict_count per accepted update with up_mispredict; 32-bit, wrapping.
REQ-019 SHALL ignore lu_valid and up_valid while ready=0 (no counters, no GHR or weight change).

Reset
REQ-020 SHALL, with reset_n low, clear GHR, counters, pred_valid, pred_taken, pred_sum, pred_ghr to 0 and hold ready=0.
REQ-021 SHALL, after reset_n release, run an init sweep of TABLE_DEPTH cycles zeroing one row per cycle from index 0; ready=1 the cycle after the last row is written.
REQ-022 SHALL restart the sweep from index 0 on reset assertion mid-sweep.

Structure
REQ-023 SHALL place default parameter values, THETA formula, debug_sel encodings and weight saturation limits in shared package bpred_pkg.
REQ-024 SHALL use one sub-module perceptron_dot (combinational signed adder tree, parametrised by HIST_LEN, WEIGHT_W); table, training, GHR, sweep and counters live in perceptron_bpred.

Verification
REQ-025 Reset release -> ready=0 for 64 cycles, then 1; lookup pc 0x40 -> next cycle pred_valid=1, pred_sum=0, pred_taken=1, pred_ghr=0x000.
REQ-026 After init, update pc 0x40, up_taken=1, up_ghr=0x000, up_sum=0, up_mispredict=0 -> w0=+1, w1..w12=-1; lookup pc 0x40 with GHR=0x000 -> pred_sum=+13, pred_taken=1.
REQ-027 130 updates pc 0x80, up_taken=1, up_ghr=0xFFF, up_sum=0 -> weights stop at +127; lookup with GHR=0x000 -> pred_sum=-1397, pred_taken=0.
REQ-028 up_valid, up_mispredict=1, up_ghr=0x0A5, up_taken=1, with lu_valid same cycle -> GHR=0x14B, pred_valid=0 next cycle, mispredict_count +1.
REQ-029 Update up_sum=+50, up_taken=1, up_mispredict=0 -> weights unchanged, update_count +1, mispredict_count unchanged.
REQ-030 reset_n low at sweep cycle 20, released -> ready=0 for full 64 cycles, all rows 0 afterwards.
